// File: rtl/mux_sel_reg_nch.sv
// NCH-channel operand mux with a single registered output stage, explicit or round-robin selection.
// Define MUX_SEL_PARITY_EN to add the registered even-parity output out_par.
module mux_sel_reg_nch #(
   parameter int WIDTH = 17,
   parameter int NCH   = 2,
   parameter int SELW  = $clog2(NCH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  mode,
   input  logic [SELW-1:0]       sel,
   input  logic [NCH-1:0]        in_valid,
   input  logic [NCH*WIDTH-1:0]  in_data,
   output logic [NCH-1:0]        in_ready,
   output logic                  out_valid,
   output logic [WIDTH-1:0]      out_data,
   output logic [SELW-1:0]       out_ch,
`ifdef MUX_SEL_PARITY_EN
   output logic                  out_par,
`endif
   input  logic                  out_ready,
   output logic                  sel_err
);

   logic [SELW-1:0]  rr_ptr;
   logic [SELW-1:0]  rr_idx;
   logic [SELW-1:0]  scan_idx;
   logic             rr_found;
   logic [SELW-1:0]  cand;
   logic             cand_ok;
   logic             sel_ok;
   logic             can_load;
   logic             grant;
   logic             err_cond;
   logic [WIDTH-1:0] chan_data;

   function automatic logic [SELW-1:0] next_idx(input logic [SELW-1:0] idx);
      return (idx == SELW'(NCH - 1)) ? '0 : idx + SELW'(1);
   endfunction

   // Scan channels starting at rr_ptr, wrapping modulo NCH; first valid wins.
   always_comb begin
      rr_found = 1'b0;
      rr_idx   = '0;
      scan_idx = rr_ptr;
      for (int k = 0; k < NCH; k++) begin
         if (!rr_found && in_valid[scan_idx]) begin
            rr_found = 1'b1;
            rr_idx   = scan_idx;
         end
         scan_idx = next_idx(scan_idx);
      end
   end

   always_comb begin
      sel_ok   = ({1'b0, sel} < (SELW + 1)'(NCH));
      can_load = !out_valid || out_ready;
      if (!mode) begin
         cand    = sel;
         cand_ok = sel_ok && in_valid[sel];
      end else begin
         cand    = rr_idx;
         cand_ok = rr_found;
      end
      grant    = rst_n && cand_ok && can_load;
      err_cond = !mode && !sel_ok && (|in_valid);
   end

   always_comb begin
      chan_data = '0;
      in_ready  = '0;
      for (int k = 0; k < NCH; k++) begin
         if (cand == SELW'(k)) chan_data = in_data[k*WIDTH +: WIDTH];
      end
      if (grant) in_ready[cand] = 1'b1;
   end

   // A grant always wins over a drain, so a full register is replaced without a bubble.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ch    <= '0;
         sel_err   <= 1'b0;
         rr_ptr    <= '0;
`ifdef MUX_SEL_PARITY_EN
         out_par   <= 1'b0;
`endif
      end else begin
         if (grant) begin
            out_valid <= 1'b1;
            out_data  <= chan_data;
            out_ch    <= cand;
`ifdef MUX_SEL_PARITY_EN
            out_par   <= ^chan_data;
`endif
            if (mode) rr_ptr <= next_idx(cand);
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
         if (err_cond) sel_err <= 1'b1;
         else if (grant) sel_err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mux_sel_reg_nch.sv
// Randomized and directed bench for mux_sel_reg_nch (NCH=3) against a transaction-level model.
// Parity output is checked when MUX_SEL_PARITY_EN is defined.
module tb_mux_sel_reg_nch;

   localparam int WIDTH = 17;
   localparam int NCH   = 3;
   localparam int SELW  = 2;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 mode;
   logic [SELW-1:0]      sel;
   logic [NCH-1:0]       in_valid;
   logic [NCH*WIDTH-1:0] in_data;
   logic [NCH-1:0]       in_ready;
   logic                 out_valid;
   logic [WIDTH-1:0]     out_data;
   logic [SELW-1:0]      out_ch;
   logic                 out_ready;
   logic                 sel_err;
`ifdef MUX_SEL_PARITY_EN
   logic                 out_par;
`endif

   int n_cmp = 0;
   int n_err = 0;

   // Model state: output register contents and round-robin pointer as plain integers.
   int               m_valid, m_ch, m_err, m_ptr, m_par;
   logic [WIDTH-1:0] m_data;

   mux_sel_reg_nch #(.WIDTH(WIDTH), .NCH(NCH)) dut (
      .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch),
`ifdef MUX_SEL_PARITY_EN
      .out_par(out_par),
`endif
      .out_ready(out_ready), .sel_err(sel_err)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic modelReset();
      m_valid = 0; m_data = '0; m_ch = 0; m_err = 0; m_ptr = 0; m_par = 0;
   endtask

   function automatic logic [NCH*WIDTH-1:0] pack3(input logic [WIDTH-1:0] c0, c1, c2);
      return {c2, c1, c0};
   endfunction

   // Called at a falling edge: drive inputs, check in_ready, clock once, check registered outputs.
   task automatic applyStimulus(input logic m, input logic [SELW-1:0] s, input logic [NCH-1:0] v,
                                input logic [NCH*WIDTH-1:0] d, input logic r);
      int cand, ok, grant;
      logic [NCH-1:0] exp_ready;
      mode = m; sel = s; in_valid = v; in_data = d; out_ready = r;
      cand = 0; ok = 0;
      if (m == 1'b0) begin
         if (int'(s) < NCH && v[s]) begin cand = int'(s); ok = 1; end
      end else begin
         for (int k = 0; k < NCH; k++) begin
            int c = (m_ptr + k) % NCH;
            if (!ok && v[c]) begin cand = c; ok = 1; end
         end
      end
      grant = ok && (!m_valid || r);
      exp_ready = grant ? NCH'(1 << cand) : '0;
      #1;
      checkOutput("in_ready", 32'(in_ready), 32'(exp_ready));
      @(posedge clk);
      if (m == 1'b0 && int'(s) >= NCH && v != 0) m_err = 1;
      else if (grant) m_err = 0;
      if (grant) begin
         m_valid = 1;
         m_data  = d[cand*WIDTH +: WIDTH];
         m_ch    = cand;
         m_par   = ^m_data;
         if (m) m_ptr = (cand + 1) % NCH;
      end else if (r) begin
         m_valid = 0;
      end
      @(negedge clk);
      checkOutput("out_valid", 32'(out_valid), 32'(m_valid));
      checkOutput("out_data", 32'(out_data), 32'(m_data));
      checkOutput("out_ch", 32'(out_ch), 32'(m_ch));
      checkOutput("sel_err", 32'(sel_err), 32'(m_err));
`ifdef MUX_SEL_PARITY_EN
      checkOutput("out_par", 32'(out_par), 32'(m_par));
`endif
   endtask

   initial begin
      int rr_exp [6];
      rr_exp = '{0, 1, 2, 0, 1, 2};
      rst_n = 1'b0; mode = 1'b0; sel = '0; in_valid = '1; out_ready = 1'b1;
      in_data = pack3(17'h00001, 17'h1ABCD, 17'h00002);
      modelReset();
      #12;
      checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
      checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_out_data", 32'(out_data), 32'd0);
      checkOutput("rst_sel_err", 32'(sel_err), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Explicit select of channel 1.
      applyStimulus(1'b0, 2'd1, 3'b111, pack3(17'h00001, 17'h1ABCD, 17'h00002), 1'b1);
      checkOutput("tp1_data", 32'(out_data), 32'h1ABCD);
      checkOutput("tp1_ch", 32'(out_ch), 32'd1);
      applyStimulus(1'b0, 2'd0, 3'b000, '0, 1'b1);

      // Round-robin over all-valid channels, starting from pointer 0.
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b1, 2'd0, 3'b111, pack3(17'h10, 17'h11, 17'h12), 1'b1);
         checkOutput("rr_seq", 32'(out_ch), 32'(rr_exp[i]));
      end
      applyStimulus(1'b1, 2'd0, 3'b010, pack3(17'h20, 17'h21, 17'h22), 1'b1);
      applyStimulus(1'b1, 2'd0, 3'b011, pack3(17'h30, 17'h31, 17'h32), 1'b1);
      checkOutput("rr_wrap_ch", 32'(out_ch), 32'd0);
      applyStimulus(1'b1, 2'd0, 3'b011, pack3(17'h40, 17'h41, 17'h42), 1'b1);
      checkOutput("rr_after_wrap_ch", 32'(out_ch), 32'd1);

      // Back-pressure holds the register, then release reloads with no bubble.
      applyStimulus(1'b0, 2'd0, 3'b001, pack3(17'h0F0F0, 17'h0, 17'h0), 1'b1);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 2'd1, 3'b111, pack3(17'h1, 17'h12345, 17'h3), 1'b0);
         checkOutput("bp_hold", 32'(out_data), 32'h0F0F0);
      end
      applyStimulus(1'b0, 2'd1, 3'b010, pack3(17'h1, 17'h12345, 17'h3), 1'b1);
      checkOutput("bp_release_data", 32'(out_data), 32'h12345);
      checkOutput("bp_release_valid", 32'(out_valid), 32'd1);

      // Out-of-range select flags an error, a later legal grant clears it.
      applyStimulus(1'b0, 2'd3, 3'b111, pack3(17'h5, 17'h6, 17'h7), 1'b1);
      checkOutput("selerr_set", 32'(sel_err), 32'd1);
      applyStimulus(1'b0, 2'd2, 3'b111, pack3(17'h5, 17'h6, 17'h7), 1'b1);
      checkOutput("selerr_clr", 32'(sel_err), 32'd0);
      checkOutput("selerr_grant_data", 32'(out_data), 32'h7);

      // Parity of a known word, then reset while the register is full.
      applyStimulus(1'b0, 2'd0, 3'b001, pack3(17'h00007, 17'h0, 17'h0), 1'b0);
`ifdef MUX_SEL_PARITY_EN
      checkOutput("par_7", 32'(out_par), 32'd1);
`endif
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_valid", 32'(out_valid), 32'd0);
      checkOutput("midrst_data", 32'(out_data), 32'd0);
      modelReset();
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 400; i++) begin
         applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                       3'($urandom_range(0, 7)),
                       (NCH*WIDTH)'({$urandom(), $urandom()}),
                       $urandom_range(0, 3) != 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mux_sel_reg_nch.md
Name: mux_sel_reg_nch

Overview:
- Parametrised successor to the 17-bit 2:1 multiply-operand mux.
- Selects one of NCH W-bit channels and delivers it through a registered output stage with a valid/ready handshake.
- Two selection modes: explicit select (multiplier datapath usage) and round-robin arbitration (shared operand bus).
- Sits between operand sources (register file, shifted-partial-product register) and the multi-cycle ALU/multiplier FSM.

Parameters:
WIDTH, 17, data width per channel in bits.
NCH, 2, number of input channels (legal range 2..16).
SELW, $clog2(NCH), select/channel-index width (derived; do not override).

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
mode  input  1  0 = explicit select via sel; 1 = round-robin among valid channels.
sel  input  SELW  channel index, used when mode=0.
in_valid  input  NCH  per-channel data valid.
in_data  input  NCH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
in_ready  output  NCH  one-hot; asserted only for the channel accepted this cycle.
out_valid  output  1  output register holds valid data.
out_data  output  WIDTH  registered selected data.
out_ch  output  SELW  index of the channel that produced out_data.
out_ready  input  1  consumer accepts out_data this cycle.
sel_err  output  1  registered flag: mode=0 and sel>=NCH was presented with in_valid pending.

Behaviour:
- Reset (async assert, sync deassert by the user): out_valid=0, out_data=0, out_ch=0, sel_err=0, round-robin pointer rr_ptr=0. in_ready is combinational and is 0 while rst_n=0.
- Single-entry output register. can_load = !out_valid || out_ready.
- Mode 0: candidate = sel. Grant only if sel<NCH, in_valid[sel]=1 and can_load. Valid flags on other channels are ignored.
- Mode 1: candidate = first k with in_valid[k]=1, searching rr_ptr, rr_ptr+1, ..., wrapping modulo NCH. On grant, rr_ptr <= granted+1, wrapping to 0 after NCH-1. rr_ptr holds when nothing is granted.
- On grant: in_ready[granted]=1 combinationally in the same cycle. Next edge: out_data <= channel data, out_ch <= granted, out_valid <= 1. Latency is 1 clock from accept to out_valid.
- Drain with no new grant: out_valid <= 0. out_data and out_ch hold their last values.
- Simultaneous drain and load (out_valid=1, out_ready=1, grant): the register is replaced with no bubble. Full throughput is 1 transfer per cycle.
- Back-pressure (out_valid=1, out_ready=0): all in_ready=0 and the output is stable (out_data and out_ch unchanged).
- sel_err: set on the edge after a cycle with mode=0, sel>=NCH, |in_valid=1. Cleared on the edge after any grant. No grant occurs while sel is out of range.
- Mode change mid-stream: takes effect the same cycle. rr_ptr is not reset by a mode change.
- in_ready is never asserted for a channel whose in_valid=0.
- Reset mid-transfer discards the held output immediately.

Optional Feature:
- Macro: MUX_SEL_PARITY_EN.
- Defined: adds output port out_par (1 bit), registered with out_data and equal to the even parity (XOR reduction) of the captured data. out_par resets to 0 and holds with out_data under back-pressure.
- Undefined: port absent. Behaviour is otherwise identical.

Test Plan:
- WIDTH=17, NCH=2, mode=0, sel=1, in_valid=2'b11, ch0=17'h00001, ch1=17'h1ABCD, out_ready=1 -> in_ready=2'b10; next cycle out_valid=1, out_data=17'h1ABCD, out_ch=1.
- NCH=4, mode=1, in_valid=4'b1111, out_ready=1 for 6 cycles -> grants 0,1,2,3,0,1 and out_ch follows one cycle later.
- NCH=4, mode=1, rr_ptr=2, in_valid=4'b0011 -> grant ch0; then rr_ptr=1.
- Back-pressure: load 17'h0F0F0 then out_ready=0 for 3 cycles -> in_ready=0, out_data stable at 17'h0F0F0. Raise out_ready with ch1 valid -> ch1 data loaded next cycle with no bubble.
- NCH=3, mode=0, sel=3, in_valid=3'b111 -> no grant; sel_err=1 next cycle. Then set sel=2 -> grant, sel_err=0 the cycle after.
- Assert rst_n=0 while out_valid=1 -> out_valid=0, out_data=0 immediately. With MUX_SEL_PARITY_EN, loading 17'h00007 gives out_par=1.
